// File: rtl/precision_restore_pipe_pkg.sv
// Shared encodings and the precision-select to shift mapping used by both the
// truncation stage and the restore pipeline.
package precision_restore_pipe_pkg;

   localparam int unsigned RESULT_W = 12;
   localparam int unsigned TRUNC_W  = 7;
   localparam int unsigned SEL_W    = 3;
   localparam int unsigned SHIFT_W  = 3;

   typedef enum logic [SEL_W-1:0] {
      PREC_HIGH = 3'd0,
      PREC_MED  = 3'd1,
      PREC_LOW  = 3'd2,
      PREC_VLOW = 3'd3,
      PREC_XLOW = 3'd4,
      PREC_MIN  = 3'd5
   } prec_sel_e;

   function automatic logic sel_is_invalid(input logic [SEL_W-1:0] sel);
      return sel > SEL_W'(PREC_MIN);
   endfunction

   // Undefined selects map to no shift so the word passes through unscaled.
   function automatic logic [SHIFT_W-1:0] sel_to_shift(input logic [SEL_W-1:0] sel);
      if (sel_is_invalid(sel)) begin
         return '0;
      end
      return SHIFT_W'(SEL_W'(PREC_MIN) - sel);
   endfunction

endpackage

// File: rtl/precision_restore_pipe_shift.sv
// Combinational re-alignment of a truncated word with optional midpoint fill
// of the vacated LSBs.
module precision_shift_bias
   import precision_restore_pipe_pkg::*;
#(
   parameter bit BIAS_EN = 1'b1
) (
   input  logic [TRUNC_W-1:0]  word_i,
   input  logic [SHIFT_W-1:0]  sh_i,
   output logic [RESULT_W-1:0] result_o
);

   logic [RESULT_W-1:0] ext;
   logic [RESULT_W-1:0] bias;

   always_comb begin
      ext  = {{(RESULT_W-TRUNC_W){1'b0}}, word_i};
      bias = '0;
      if (BIAS_EN && (sh_i != '0)) begin
         bias = RESULT_W'(1) << (sh_i - SHIFT_W'(1));
      end
      result_o = (ext << sh_i) | bias;
   end

endmodule

// File: rtl/precision_restore_pipe.sv
// Two-stage valid/ready pipeline restoring truncated words to full result
// scale, with delivered-sample and select-error counters.
module precision_restore_pipe
   import precision_restore_pipe_pkg::*;
#(
   parameter bit          BIAS_EN = 1'b1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                In_valid,
   output logic                In_ready,
   input  logic [TRUNC_W-1:0]  Truncated_result,
   input  logic [SEL_W-1:0]    SEL,
   output logic                Out_valid,
   input  logic                Out_ready,
   output logic [RESULT_W-1:0] Restored_result,
   output logic [SEL_W-1:0]    Out_SEL,
   output logic                Sel_error,
   output logic [CNT_W-1:0]    Sample_count,
   output logic [CNT_W-1:0]    Error_count,
   input  logic                Clear_counts
);

   logic                s1_valid_q, s1_valid_d;
   logic [TRUNC_W-1:0]  s1_word_q,  s1_word_d;
   logic [SEL_W-1:0]    s1_sel_q,   s1_sel_d;
   logic [SHIFT_W-1:0]  s1_sh_q,    s1_sh_d;
   logic                s1_err_q,   s1_err_d;

   logic                s2_valid_q,  s2_valid_d;
   logic [RESULT_W-1:0] s2_result_q, s2_result_d;
   logic [SEL_W-1:0]    s2_sel_q,    s2_sel_d;
   logic                s2_err_q,    s2_err_d;

   logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

   logic                s2_can_load;
   logic                in_fire;
   logic                out_fire;
   logic [RESULT_W-1:0] restored;

   precision_shift_bias #(.BIAS_EN(BIAS_EN)) u_shift (
      .word_i   (s1_word_q),
      .sh_i     (s1_sh_q),
      .result_o (restored)
   );

   assign out_fire    = s2_valid_q & Out_ready;
   assign s2_can_load = ~s2_valid_q | Out_ready;
   assign In_ready    = ~s1_valid_q | s2_can_load;
   assign in_fire     = In_valid & In_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_word_d   = s1_word_q;
      s1_sel_d    = s1_sel_q;
      s1_sh_d     = s1_sh_q;
      s1_err_d    = s1_err_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_sel_d    = s2_sel_q;
      s2_err_d    = s2_err_q;
      smp_cnt_d   = smp_cnt_q;
      err_cnt_d   = err_cnt_q;

      // Stage 2 follows stage 1 whenever it may load; an empty stage 1 empties it.
      if (s2_can_load) begin
         s2_valid_d  = s1_valid_q;
         s2_result_d = restored;
         s2_sel_d    = s1_sel_q;
         s2_err_d    = s1_err_q;
      end

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_word_d  = Truncated_result;
         s1_sel_d   = SEL;
         s1_sh_d    = sel_to_shift(SEL);
         s1_err_d   = sel_is_invalid(SEL);
      end else if (s2_can_load) begin
         s1_valid_d = 1'b0;
      end

      if (out_fire) begin
         smp_cnt_d = smp_cnt_q + CNT_W'(1);
         if (s2_err_q) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end
      if (Clear_counts) begin
         smp_cnt_d = '0;
         err_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_word_q   <= '0;
         s1_sel_q    <= '0;
         s1_sh_q     <= '0;
         s1_err_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_sel_q    <= '0;
         s2_err_q    <= 1'b0;
         smp_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_word_q   <= s1_word_d;
         s1_sel_q    <= s1_sel_d;
         s1_sh_q     <= s1_sh_d;
         s1_err_q    <= s1_err_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_sel_q    <= s2_sel_d;
         s2_err_q    <= s2_err_d;
         smp_cnt_q   <= smp_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign Out_valid       = s2_valid_q;
   assign Restored_result = s2_result_q;
   assign Out_SEL         = s2_sel_q;
   assign Sel_error       = s2_err_q;
   assign Sample_count    = smp_cnt_q;
   assign Error_count     = err_cnt_q;

endmodule

// File: tb/tb_precision_restore_pipe.sv
// Bench for precision_restore_pipe: zero-fill and midpoint-fill instances share
// stimulus; the midpoint instance uses narrow counters to exercise wrap.
module tb_precision_restore_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [6:0]  word;
   logic [2:0]  sel;
   logic        out_ready;
   logic        clear;

   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [11:0] res0, res1;
   logic [2:0]  osel0, osel1;
   logic        serr0, serr1;
   logic [15:0] sc0, ec0;
   logic [3:0]  sc1, ec1;

   int total = 0;
   int bad   = 0;
   int m_samp = 0;
   int m_err  = 0;

   typedef struct {
      logic [11:0] r0;
      logic [11:0] r1;
      logic [2:0]  s;
      logic        e;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic [6:0]  w;
      logic [2:0]  s;
      logic [11:0] e0;
      logic [11:0] e1;
      logic        err;
   } vec_t;
   vec_t vecs[9];

   always #5 clk = ~clk;

   precision_restore_pipe #(.BIAS_EN(1'b0), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .In_valid(in_valid), .In_ready(in_ready0),
      .Truncated_result(word), .SEL(sel), .Out_valid(out_valid0),
      .Out_ready(out_ready), .Restored_result(res0), .Out_SEL(osel0),
      .Sel_error(serr0), .Sample_count(sc0), .Error_count(ec0),
      .Clear_counts(clear)
   );

   precision_restore_pipe #(.BIAS_EN(1'b1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .In_valid(in_valid), .In_ready(in_ready1),
      .Truncated_result(word), .SEL(sel), .Out_valid(out_valid1),
      .Out_ready(out_ready), .Restored_result(res1), .Out_SEL(osel1),
      .Sel_error(serr1), .Sample_count(sc1), .Error_count(ec1),
      .Clear_counts(clear)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Plain arithmetic: scale by 2^sh, add half an LSB of the restored scale.
   function automatic int ref_restore(input int w, input int s, input bit bias);
      int sh;
      int v;
      sh = (s <= 5) ? 5 - s : 0;
      v  = w * (2 ** sh);
      if (bias && sh > 0) v = v + 2 ** (sh - 1);
      return v;
   endfunction

   task automatic step(input bit iv, input logic [6:0] w, input logic [2:0] s,
                       input bit ordy, input bit clr, output bit fired, output bit ir);
      exp_t e;
      @(negedge clk);
      in_valid = iv; word = w; sel = s; out_ready = ordy; clear = clr;
      #3;
      chk("sample_cnt0", sc0, 32'(m_samp % 65536));
      chk("error_cnt0",  ec0, 32'(m_err % 65536));
      chk("sample_cnt1", sc1, 32'(m_samp % 16));
      chk("error_cnt1",  ec1, 32'(m_err % 16));
      chk("in_ready0", in_ready0, 32'((q.size() < 2) || ordy));
      chk("in_ready1", in_ready1, 32'((q.size() < 2) || ordy));
      ir = in_ready0;
      if (out_valid0) begin
         if (q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
         end else begin
            chk("result0",   res0, q[0].r0);
            chk("result1",   res1, q[0].r1);
            chk("out_sel",   osel0, q[0].s);
            chk("sel_error", serr0, q[0].e);
            chk("out_valid1", out_valid1, 1);
            if (ordy) begin
               m_samp++;
               if (q[0].e) m_err++;
               void'(q.pop_front());
            end
         end
      end
      if (clr) begin
         m_samp = 0;
         m_err  = 0;
      end
      fired = iv && in_ready0;
      if (fired) begin
         e.r0 = 12'(ref_restore(int'(w), int'(s), 1'b0));
         e.r1 = 12'(ref_restore(int'(w), int'(s), 1'b1));
         e.s  = s;
         e.e  = (s > 3'd5);
         q.push_back(e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit f, ir, saw_block;
      int n;

      vecs[0] = '{7'h7F, 3'd0, 12'hFE0, 12'hFF0, 1'b0};
      vecs[1] = '{7'h01, 3'd2, 12'h008, 12'h00C, 1'b0};
      vecs[2] = '{7'h55, 3'd5, 12'h055, 12'h055, 1'b0};
      vecs[3] = '{7'h3A, 3'd6, 12'h03A, 12'h03A, 1'b1};
      vecs[4] = '{7'h3A, 3'd7, 12'h03A, 12'h03A, 1'b1};
      vecs[5] = '{7'h00, 3'd0, 12'h000, 12'h010, 1'b0};
      vecs[6] = '{7'h11, 3'd3, 12'h044, 12'h046, 1'b0};
      vecs[7] = '{7'h7F, 3'd1, 12'h7F0, 12'h7F8, 1'b0};
      vecs[8] = '{7'h7F, 3'd5, 12'h07F, 12'h07F, 1'b0};

      rst = 1'b1; in_valid = 1'b0; word = '0; sel = '0; out_ready = 1'b0; clear = 1'b0;
      #1;
      chk("rst_out_valid", out_valid0, 0);
      chk("rst_result",    res0, 0);
      chk("rst_sel_error", serr0, 0);
      chk("rst_sample",    sc0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         in_valid = 1'b1; word = vecs[i].w; sel = vecs[i].s; out_ready = 1'b1;
         @(posedge clk); #1;
         chk("tbl_lat1_valid", out_valid0, 0);
         @(negedge clk) in_valid = 1'b0;
         @(posedge clk); #1;
         chk("tbl_valid",   out_valid0, 1);
         chk("tbl_result0", res0, vecs[i].e0);
         chk("tbl_result1", res1, vecs[i].e1);
         chk("tbl_out_sel", osel0, vecs[i].s);
         chk("tbl_sel_err", serr0, vecs[i].err);
         m_samp++;
         if (vecs[i].err) m_err++;
         @(posedge clk); #1;
         chk("tbl_drained",  out_valid0, 0);
         chk("tbl_samples",  sc0, 32'(m_samp));
         chk("tbl_errors",   ec0, 32'(m_err));
      end

      for (int c = 0; c < 300; c++) begin
         step($urandom_range(0, 3) != 0, 7'($urandom), 3'($urandom_range(0, 7)),
              $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, f, ir);
      end
      for (int c = 0; c < 20 && q.size() > 0; c++) step(1'b0, '0, '0, 1'b1, 1'b0, f, ir);
      chk("random_drain", q.size(), 0);

      // Two words in flight, then an asynchronous reset between edges.
      step(1'b1, 7'h21, 3'd1, 1'b0, 1'b0, f, ir);
      step(1'b1, 7'h42, 3'd6, 1'b0, 1'b0, f, ir);
      @(posedge clk); #2;
      chk("pre_rst_valid", out_valid0, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid0", out_valid0, 0);
      chk("mid_rst_valid1", out_valid1, 0);
      chk("mid_rst_sample", sc0, 0);
      chk("mid_rst_error",  ec0, 0);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      q.delete();
      m_samp = 0;
      m_err  = 0;

      n = 0; saw_block = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step(n < 8, 7'(n * 9 + 3), 3'(n % 8), !(c >= 3 && c < 8), 1'b0, f, ir);
         if (f) n++;
         if (!ir) saw_block = 1'b1;
      end
      chk("bp_all_in",     n, 8);
      chk("bp_queue",      q.size(), 0);
      chk("bp_stall_seen", saw_block, 1);
      @(negedge clk); #3;
      chk("bp_samples", sc0, 8);

      step(1'b1, 7'h0F, 3'd4, 1'b0, 1'b0, f, ir);
      step(1'b0, '0, '0, 1'b0, 1'b0, f, ir);
      step(1'b0, '0, '0, 1'b1, 1'b1, f, ir);
      @(negedge clk); #3;
      chk("clr_win_sample", sc0, 0);
      chk("clr_win_error",  ec0, 0);
      chk("clr_win_sample1", sc1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
